// File: rtl/sd_adc_cic_decimator_if.sv
// ---------------------------------------------------------------------------
// sd_adc_cic_decimator_if
// Bitstream-in / sample-out bundle for the sigma-delta CIC decimator.
//   i_ce    : bit-rate clock enable (source -> decimator)
//   i_bit   : 1-bit sigma-delta stream (source -> decimator)
//   o_data  : decimated offset-binary sample, held between updates
//   o_valid : one-cycle pulse when o_data updates
//   o_ovf   : sticky clamp flag
// Modports: master = bitstream source / sample consumer, slave = decimator.
// ---------------------------------------------------------------------------
interface sd_adc_cic_decimator_if #(
    parameter int OUT_W = 16
);
    logic             i_ce;
    logic             i_bit;
    logic [OUT_W-1:0] o_data;
    logic             o_valid;
    logic             o_ovf;

    modport master (
        output i_ce,
        output i_bit,
        input  o_data,
        input  o_valid,
        input  o_ovf
    );

    modport slave (
        input  i_ce,
        input  i_bit,
        output o_data,
        output o_valid,
        output o_ovf
    );
endinterface

// File: rtl/sd_adc_cic_decimator.sv
// ---------------------------------------------------------------------------
// sd_adc_cic_decimator
// Third-order CIC decimator turning a 1-bit sigma-delta stream into
// offset-binary samples (0 = most negative, 2^(OUT_W-1) = mid-scale,
// all-ones = full-scale). Integrators run at the bit rate (i_ce), combs run
// once per R = 2^DECIM_LOG2 input bits.
//
// Ports:
//   i_clk : system clock
//   i_res : synchronous active-high reset (overrides i_ce)
//   bus   : sd_adc_cic_decimator_if.slave (i_ce, i_bit, o_data, o_valid, o_ovf)
//
// Build option:
//   SD_ADC_INPUT_SYNC_EN - when defined, i_bit passes through a two-flop
//   synchronizer clocked every i_clk cycle (for an asynchronous comparator).
//   When undefined, i_bit is consumed directly.
// ---------------------------------------------------------------------------
module sd_adc_cic_decimator #(
    parameter int DECIM_LOG2 = 6,
    parameter int OUT_W      = 16
) (
    input  logic                   i_clk,
    input  logic                   i_res,
    sd_adc_cic_decimator_if.slave  bus
);
    localparam int W = 3 * DECIM_LOG2 + 1;

    logic                  bit_s;
    logic [W-1:0]          x;
    logic [W-1:0]          i1_q, i2_q, i3_q;
    logic [W-1:0]          d1_q, d2_q, d3_q;
    logic [W-1:0]          c1, c2, c3;
    logic [DECIM_LOG2-1:0] cnt_q;
    logic                  comb_pend_q;
    logic [OUT_W-1:0]      scaled;
    logic [OUT_W-1:0]      data_q;
    logic                  valid_q;
    logic                  ovf_q;

`ifdef SD_ADC_INPUT_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], bus.i_bit};
        end
    end

    assign bit_s = sync_q[1];
`else
    assign bit_s = bus.i_bit;
`endif

    assign x = {{(W-1){1'b0}}, bit_s};

    // Comb differences are combinational off the delay registers; the
    // result is registered into o_data at the edge after a decimation edge.
    always_comb begin
        c1 = i3_q - d1_q;
        c2 = c1 - d2_q;
        c3 = c2 - d3_q;
    end

    // Steady-state C3 spans 0..2^(W-1); take the OUT_W bits just below the
    // overflow bit, left-justifying when the filter is narrower than OUT_W.
    generate
        if (W - 1 > OUT_W) begin : g_trunc
            logic unused_lsbs;
            assign scaled      = c3[W-2 -: OUT_W];
            assign unused_lsbs = ^c3[W-OUT_W-2:0];
        end else if (W - 1 == OUT_W) begin : g_exact
            assign scaled = c3[W-2:0];
        end else begin : g_pad
            assign scaled = {c3[W-2:0], {(OUT_W-W+1){1'b0}}};
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            i1_q        <= '0;
            i2_q        <= '0;
            i3_q        <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            d3_q        <= '0;
            cnt_q       <= '0;
            comb_pend_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            valid_q <= 1'b0;

            if (bus.i_ce) begin
                i1_q  <= i1_q + x;
                i2_q  <= i2_q + i1_q;
                i3_q  <= i3_q + i2_q;
                cnt_q <= cnt_q + 1'b1;
            end

            // The counter wraps naturally at R-1; sampling there marks
            // the decimation edge, and the comb runs on the following edge
            // regardless of i_ce.
            comb_pend_q <= bus.i_ce && (cnt_q == '1);

            if (comb_pend_q) begin
                d1_q    <= i3_q;
                d2_q    <= c1;
                d3_q    <= c2;
                valid_q <= 1'b1;
                if (c3[W-1]) begin
                    data_q <= '1;
                    ovf_q  <= 1'b1;
                end else begin
                    data_q <= scaled;
                end
            end
        end
    end

    assign bus.o_data  = data_q;
    assign bus.o_valid = valid_q;
    assign bus.o_ovf   = ovf_q;
endmodule

// File: tb/tb_sd_adc_cic_decimator.sv
// ---------------------------------------------------------------------------
// tb_sd_adc_cic_decimator
// Randomized bench for sd_adc_cic_decimator (DECIM_LOG2 = 6). The reference
// keeps the raw sampled bit history and evaluates the decimated value as a
// closed-form weighted sum: a triple running sum of the bits gives
// F(n) = sum_k x[k]*C(n-k,2), and each output is the third R-step difference
// of F at the decimation sample. Expected o_valid timing follows from the
// count of sampled bits.
// ---------------------------------------------------------------------------
module tb_sd_adc_cic_decimator;
    localparam int DL    = 6;
    localparam int R     = 1 << DL;
    localparam int W     = 3 * DL + 1;
    localparam int OUT_W = 16;

    logic clk = 1'b0;
    logic res;

    always #5 clk = ~clk;

    sd_adc_cic_decimator_if #(.OUT_W(OUT_W)) bus ();

    sd_adc_cic_decimator #(
        .DECIM_LOG2 (DL),
        .OUT_W      (OUT_W)
    ) dut (
        .i_clk (clk),
        .i_res (res),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    bit       hist[$];
    logic     dec_prev;
    int       pulse_cnt;
    int       exp_data;
    logic     exp_ovf;
    int       pend_data;
    logic     pend_ovf;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint f_at(input int n);
        longint s = 0;
        if (n < 0) return 0;
        for (int k = 0; k <= n; k++) begin
            if (hist[k]) s += longint'(n - k) * longint'(n - k - 1) / 2;
        end
        return s;
    endfunction

    function automatic longint cic_out(input int a);
        return f_at(a) - 3 * f_at(a - R) + 3 * f_at(a - 2 * R) - f_at(a - 3 * R);
    endfunction

    // One clock: drive inputs, advance past the edge, then check outputs
    // against the reference and feed the sampled bit into the history.
    task automatic cycle(input logic r, input logic ce, input logic b);
        longint c;
        res       = r;
        bus.i_ce  = ce;
        bus.i_bit = b;
        @(posedge clk);
        #1;
        if (r) begin
            hist.delete();
            dec_prev  = 1'b0;
            pulse_cnt = 0;
            exp_data  = 0;
            exp_ovf   = 1'b0;
            check_val("rst_valid", {31'd0, bus.o_valid}, 32'd0);
            check_val("rst_data", {16'd0, bus.o_data}, 32'd0);
            check_val("rst_ovf", {31'd0, bus.o_ovf}, 32'd0);
        end else begin
            check_val("valid", {31'd0, bus.o_valid}, {31'd0, dec_prev});
            if (dec_prev) begin
                pulse_cnt++;
                exp_data = pend_data;
                if (pend_ovf) exp_ovf = 1'b1;
            end
            // Pulses 1..3 after reset are settling transients.
            if (pulse_cnt == 0 || pulse_cnt >= 4)
                check_val("data", {16'd0, bus.o_data}, exp_data);
            check_val("ovf", {31'd0, bus.o_ovf}, {31'd0, exp_ovf});
            dec_prev = 1'b0;
            if (ce) begin
                hist.push_back(b);
                if (hist.size() % R == 0) begin
                    dec_prev = 1'b1;
                    c = cic_out(hist.size() - 1);
                    if (c >= (longint'(1) << (W - 1))) begin
                        pend_data = 65535;
                        pend_ovf  = 1'b1;
                    end else begin
                        pend_data = int'(c >> (W - 1 - OUT_W));
                        pend_ovf  = 1'b0;
                    end
                end
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        int p;

        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);

        // Constant 0
        for (int i = 0; i < 6 * R; i++) cycle(1'b0, 1'b1, 1'b0);
        check_val("zero_data", {16'd0, bus.o_data}, 32'd0);
        check_val("zero_ovf", {31'd0, bus.o_ovf}, 32'd0);

        // Alternating 1,0
        for (int i = 0; i < 6 * R; i++) cycle(1'b0, 1'b1, 1'(i % 2));
        check_val("alt_mid", {16'd0, bus.o_data}, 32'd32768);

        // One-in-four
        for (int i = 0; i < 6 * R; i++) cycle(1'b0, 1'b1, 1'((i % 4) == 0));
        check_val("quarter", {16'd0, bus.o_data}, 32'd16384);

        // All ones -> clamp and sticky overflow
        for (int i = 0; i < 6 * R; i++) cycle(1'b0, 1'b1, 1'b1);
        check_val("full_data", {16'd0, bus.o_data}, 32'd65535);
        check_val("full_ovf", {31'd0, bus.o_ovf}, 32'd1);

        for (int i = 0; i < 4 * R; i++) cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        check_val("ovf_sticky", {31'd0, bus.o_ovf}, 32'd1);

        cycle(1'b1, 1'b1, 1'b1);
        check_val("ovf_cleared", {31'd0, bus.o_ovf}, 32'd0);

        // Clock-enable gating: 1 cycle in 4, alternating bits per sample
        for (int i = 0; i < 6 * R * 4; i++) cycle(1'b0, 1'((i % 4) == 0), 1'((i / 4) % 2));
        check_val("gated_mid", {16'd0, bus.o_data}, 32'd32768);
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        check_val("frozen_data", {16'd0, bus.o_data}, 32'd32768);

        // Reset mid-frame: 4 frames plus 30 samples, then reset
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4 * R + 30; i++) cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        cycle(1'b1, 1'b1, 1'b1);
        lat = 0;
        for (int j = 1; j <= 200; j++) begin
            cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)));
            if (bus.o_valid === 1'b1) begin
                lat = j;
                break;
            end
        end
        check_val("rst_latency", lat, R + 1);

        // Random density and random enable
        for (int seg = 0; seg < 4; seg++) begin
            p = $urandom_range(5, 95);
            for (int i = 0; i < 8 * R; i++)
                cycle(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) < p));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sd_adc_cic_decimator.md
Name: sd_adc_cic_decimator

Overview:
- Receive-side counterpart of second_order_dac: converts a 1-bit sigma-delta bitstream into 16-bit offset-binary samples.
- Bitstream source: external comparator/modulator, or the DAC output for loopback.
- Structure: 3rd-order CIC decimator (integrators at bit rate, combs at output rate) with power-of-two decimation.
- Output coding matches the DAC's i_func coding, so loopback returns the original code: 0 = most negative, 32768 = mid-scale, 65535 = full-scale.

Parameters:
- DECIM_LOG2, 6: log2 of decimation ratio R; R = 2^DECIM_LOG2. Legal range 4..8.
- OUT_W, 16: output sample width.
- Internal width W = 3*DECIM_LOG2 + 1, derived and not overridable. Default W = 19.

Ports:
- i_clk  in  1  system clock.
- i_res  in  1  synchronous active-high reset.
- i_ce  in  1  bit-rate clock enable; bitstream sampled only when high.
- i_bit  in  1  sigma-delta bitstream; 1 = +full-scale, 0 = -full-scale.
- o_data  out  OUT_W  decimated sample, offset-binary, held between updates.
- o_valid  out  1  one-cycle pulse when o_data updates.
- o_ovf  out  1  sticky flag: a sample was clamped to 65535; cleared only by i_res.

Behaviour:
- Reset (i_res high at a rising edge): clears integrators, comb delay registers, decimation counter, o_data (0), o_valid (0) and o_ovf (0). Reset overrides i_ce. Reset mid-frame discards the partial frame; counting restarts at 0 on the first i_ce after release.
- Input mapping: x = i_bit (0 or 1), zero-extended to W bits.
- Integrators: three registered stages (I1 += x; I2 += I1; I3 += I2).
  - Update only on clock edges with i_ce = 1.
  - Arithmetic is modulo 2^W; wrap-around is intended and must not be saturated.
- Decimation counter: 0..R-1, advances on each i_ce cycle and wraps R-1 -> 0.
  - The edge that samples with the counter at R-1 is the decimation edge.
- Comb section: on the clock edge after a decimation edge, whether or not i_ce is high:
  - C1 = I3 - D1, C2 = C1 - D2, C3 = C2 - D3, all modulo 2^W, each with a single-sample delay.
  - D1..D3 are updated at the same edge.
  - o_data and o_valid register at that same edge, so o_valid is high exactly one cycle per R i_ce cycles.
- Scaling: steady-state C3 range is 0..R^3 = 2^(W-1).
  - o_data = C3[W-2 : W-1-OUT_W].
  - If C3[W-1] is set (all-ones input), clamp o_data to 65535 and set o_ovf.
- Settling: the first 3 o_valid pulses after reset (integrator pipeline plus comb fill) carry transient data. Pulse 4 onward is exact for a stationary input.
- i_ce low for long stretches: state is frozen. A pending comb evaluation still completes the cycle after its decimation edge.
- i_ce may be high continuously; there is no minimum spacing.

Optional Feature:
- Macro: SD_ADC_INPUT_SYNC_EN.
- Defined: i_bit passes through a two-flop synchronizer clocked every i_clk cycle, for use with an asynchronous external comparator.
  - The integrators consume the synchronized bit.
  - Adds 2 i_clk cycles of bitstream latency; o_valid timing relative to the counter is unchanged.
  - Synchronizer flops reset to 0.
- Undefined: i_bit is used directly with no added flops; the source must be synchronous to i_clk.

Test Plan:
- Common setup for all scenarios: DECIM_LOG2 = 6 and i_ce = 1 unless noted.
- Constant 0: i_bit = 0 -> from 4th o_valid, o_data = 0; o_ovf stays 0.
- Alternating 1,0: i_bit alternating -> o_data = 32768 steady; o_valid period exactly 64 clocks.
- One-in-four: i_bit pattern 1000 repeating -> o_data = 16384. Then all-ones -> o_data = 65535 and o_ovf = 1 stays set until i_res.
- Clock-enable gating: i_ce high 1 cycle in 4 with alternating bits -> o_data = 32768; o_valid period 256 clocks; a stretch of i_ce low holds o_data with no o_valid.
- Reset mid-frame: pulse i_res after 30 samples of frame 5 -> the next cycle shows o_data = 0, o_valid = 0, o_ovf = 0; the next o_valid is exactly 64 i_ce cycles after release plus 1.
- Loopback: feed second_order_dac o_DAC into i_bit (shared i_clk, i_ce = 1) with i_func = 80, 32766, 32770, 65080 in turn, 1000 cycles each -> after settling, o_data is within ±4 LSB of each i_func value.
